// File: rtl/mips_pkg.sv
// Shared definitions for the syscall service block:
// call codes and the service state encoding.
package mips_pkg;

  localparam logic [31:0] SYS_PRINT_INT = 32'd1;
  localparam logic [31:0] SYS_EXIT      = 32'd10;
  localparam logic [31:0] SYS_PAUSE     = 32'd50;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW    = 2'd1,
    WAIT_GO = 2'd2,
    HALTED  = 2'd3
  } sys_state_t;

  function automatic logic is_call(
    input logic [31:0] code
  );
    return (code == SYS_PRINT_INT) ||
           (code == SYS_EXIT) ||
           (code == SYS_PAUSE);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered 1-bit rising-edge detector.
// Ports: clk, rst_n (sync, active-low), d_i level in, rise_o pulse out.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic hist_q;

  // History resets high so a level held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) hist_q <= 1'b1;
    else        hist_q <= d_i;
  end

  assign rise_o = d_i & ~hist_q;

endmodule

// File: rtl/syscall_unit.sv
// Services print-int, exit and pause syscalls and stalls the CPU.
// Ports: clk, rst_n, syscall, v0, a0, go in; stall, halted, disp_* out.
module syscall_unit
  import mips_pkg::*;
#(
  parameter int DISP_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             syscall,
  input  logic [31:0]      v0,
  input  logic [31:0]      a0,
  input  logic             go,
  output logic             stall,
  output logic             halted,
  output logic [31:0]      disp_data,
  output logic             disp_valid,
  output logic [CNT_W-1:0] print_count
);

  localparam int HW =
    (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_INIT =
    HW'(DISP_CYCLES - 1);

  sys_state_t       state_q;
  logic [HW-1:0]    hold_q;
  logic [31:0]      disp_data_q;
  logic             disp_valid_q;
  logic             halted_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             go_rise;

  rise_detect u_go_rise (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (go),
    .rise_o (go_rise)
  );

  assign cnt_d = (&cnt_q) ? cnt_q
                          : cnt_q + CNT_W'(1);

  // Combinational so the syscall is held before it retires.
  assign stall = (state_q != IDLE) ||
                 (syscall && is_call(v0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      disp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (syscall) begin
            case (v0)
              SYS_PRINT_INT: begin
                disp_data_q  <= a0;
                disp_valid_q <= 1'b1;
                cnt_q        <= cnt_d;
                hold_q       <= HOLD_INIT;
                state_q      <= SHOW;
              end
              SYS_EXIT: begin
                halted_q <= 1'b1;
                state_q  <= HALTED;
              end
              SYS_PAUSE: begin
                state_q <= WAIT_GO;
              end
              default: ;
            endcase
          end
        end
        SHOW: begin
          if (hold_q == '0) state_q <= IDLE;
          else              hold_q  <= hold_q - HW'(1);
        end
        WAIT_GO: begin
          if (go_rise) state_q <= IDLE;
        end
        HALTED: ;
      endcase
    end
  end

  assign halted      = halted_q;
  assign disp_data   = disp_data_q;
  assign disp_valid  = disp_valid_q;
  assign print_count = cnt_q;

endmodule
